// File: rtl/matc_streamer.sv
// Streams DEPTH signed result words out of a synchronous-read RAM with a valid/ready
// handshake, accumulating a running sum and signed maximum of the accepted words.
module matc_streamer #(
  parameter int DW    = 19,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic [AW-1:0]               rd_addr,
  input  logic signed [DW-1:0]        rd_data,
  output logic signed [DW-1:0]        out_data,
  output logic [AW-1:0]               out_addr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done,
  output logic signed [DW+AW-1:0]     sum,
  output logic signed [DW-1:0]        max_val
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, FINISH} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t                     state_q, state_d;
  logic [AW-1:0]              cnt_d;
  logic signed [DW-1:0]       out_data_d;
  logic [AW-1:0]              out_addr_d;
  logic                       out_valid_d;
  logic                       busy_d;
  logic                       done_d;
  logic signed [DW+AW-1:0]    sum_d;
  logic signed [DW-1:0]       max_d;
  logic                       first_q, first_d;
  logic                       handshake;

  assign handshake = out_valid && out_ready;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = rd_addr;
    out_data_d  = out_data;
    out_addr_d  = out_addr;
    out_valid_d = out_valid;
    sum_d       = sum;
    max_d       = max_val;
    first_d     = first_q;

    unique case (state_q)
      IDLE, FINISH: begin
        if (start) begin
          state_d = FETCH;
          cnt_d   = '0;
          sum_d   = '0;
          max_d   = '0;
          first_d = 1'b1;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        // rd_data now reflects the address presented during FETCH.
        out_data_d  = rd_data;
        out_addr_d  = rd_addr;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (handshake) begin
          sum_d       = sum + {{AW{out_data[DW-1]}}, out_data};
          if (first_q || (out_data > max_val)) max_d = out_data;
          first_d     = 1'b0;
          out_valid_d = 1'b0;
          if (rd_addr == LAST_ADDR) begin
            state_d = FINISH;
          end else begin
            cnt_d   = rd_addr + 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == FETCH) || (state_d == LOAD) || (state_d == SEND);
    done_d = (state_d == FINISH);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_addr   <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      max_val   <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr   <= cnt_d;
      out_data  <= out_data_d;
      out_addr  <= out_addr_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      sum       <= sum_d;
      max_val   <= max_d;
      first_q   <= first_d;
    end
  end

endmodule

// File: tb/tb_matc_streamer.sv
// Self-checking bench for matc_streamer: RAM model, scoreboard of expected words,
// stall / mid-stream reset / restart scenarios.
module tb_matc_streamer;

  localparam int DW    = 19;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic [AW-1:0]            rd_addr;
  logic signed [DW-1:0]     rd_data;
  logic signed [DW-1:0]     out_data;
  logic [AW-1:0]            out_addr;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     done;
  logic signed [DW+AW-1:0]  sum;
  logic signed [DW-1:0]     max_val;

  matc_streamer #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .sum(sum), .max_val(max_val)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] ram [DEPTH];
  always @(posedge clk) rd_data <= ram[rd_addr];

  typedef struct {
    logic [AW-1:0]        addr;
    logic signed [DW-1:0] data;
  } word_t;

  word_t                   exp_q[$];
  int                      n_cmp = 0;
  int                      n_err = 0;
  logic signed [DW+AW-1:0] exp_sum;
  logic signed [DW-1:0]    exp_max;

  // Scoreboard fill plus reference sum / max from the RAM image.
  task automatic load_expect();
    exp_q.delete();
    exp_sum = '0;
    exp_max = ram[0];
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back('{addr: AW'(i), data: ram[i]});
      exp_sum = exp_sum + (DW+AW)'(ram[i]);
      if (ram[i] > exp_max) exp_max = ram[i];
    end
  endtask

  // Returns on the falling edge right after the DUT enters FETCH.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_stream(input int stall_addr, input int stall_len, input int stop_addr,
                            input int start_iter, input int exp_cycles);
    int    stalled = 0;
    int    hs = 0;
    bit    fin = 1'b0;
    word_t w;
    for (int iter = 1; iter <= 2000; iter++) begin
      start = (iter == start_iter);
      if (done) begin
        fin = 1'b1;
        if (exp_cycles >= 0) begin
          n_cmp++;
          if (iter - 1 !== exp_cycles) begin
            n_err++;
            $display("FAIL done_latency: got %0d cycles, expected %0d", iter - 1, exp_cycles);
          end
        end
        break;
      end
      if (out_valid && int'(out_addr) == stop_addr) begin
        reset = 1'b1;
        fin   = 1'b1;
        break;
      end
      if (out_valid && int'(out_addr) == stall_addr && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
        n_cmp++;
        if (exp_q.size() == 0 || out_data !== exp_q[0].data || out_addr !== exp_q[0].addr) begin
          n_err++;
          $display("FAIL stall_stable: got addr %0d data %0d", out_addr, out_data);
        end
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          hs++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL extra_word: got addr %0d data %0d, expected none", out_addr, out_data);
          end else begin
            w = exp_q.pop_front();
            if (out_data !== w.data || out_addr !== w.addr) begin
              n_err++;
              $display("FAIL word: got addr %0d data %0d, expected addr %0d data %0d",
                       out_addr, out_data, w.addr, w.data);
            end
          end
          if (stall_len == 0) begin
            n_cmp++;
            if (iter !== 3 * hs) begin
              n_err++;
              $display("FAIL throughput: word %0d at cycle %0d, expected %0d", hs - 1, iter, 3 * hs);
            end
          end
        end
      end
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (!fin) begin
      n_err++;
      $display("FAIL timeout: got no completion, expected done within 2000 cycles");
    end
    if (stop_addr < 0 && fin) begin
      n_cmp += 4;
      if (hs !== DEPTH) begin
        n_err++;
        $display("FAIL word_count: got %0d, expected %0d", hs, DEPTH);
      end
      if (sum !== exp_sum) begin
        n_err++;
        $display("FAIL sum: got %0d, expected %0d", sum, exp_sum);
      end
      if (max_val !== exp_max) begin
        n_err++;
        $display("FAIL max_val: got %0d, expected %0d", max_val, exp_max);
      end
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL busy_in_finish: got %0b, expected 0", busy);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if (rd_addr !== '0 || out_data !== '0 || out_addr !== '0 || out_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || sum !== '0 || max_val !== '0) begin
      n_err++;
      $display("FAIL %s: got rd_addr %0d out_data %0d out_addr %0d valid %0b busy %0b done %0b sum %0d max %0d, expected all 0",
               tag, rd_addr, out_data, out_addr, out_valid, busy, done, sum, max_val);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle_no_start");
  endtask

  task automatic test_ramp();
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
    load_expect();
    n_cmp += 2;
    if (exp_sum !== (DW+AW)'(2016)) begin
      n_err++;
      $display("FAIL ramp_model_sum: got %0d, expected 2016", exp_sum);
    end
    if (exp_max !== DW'(63)) begin
      n_err++;
      $display("FAIL ramp_model_max: got %0d, expected 63", exp_max);
    end
    pulse_start();
    run_stream(-1, 0, -1, -1, 192);
  endtask

  task automatic test_negative();
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(-262144);
    load_expect();
    pulse_start();
    run_stream(-1, 0, -1, -1, 192);
    n_cmp++;
    if (sum !== -(DW+AW)'(16777216)) begin
      n_err++;
      $display("FAIL negative_sum: got %0d, expected -16777216", sum);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
    load_expect();
    pulse_start();
    run_stream(5, 10, -1, -1, 202);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 100);
    load_expect();
    pulse_start();
    run_stream(-1, 0, 20, -1, -1);
    @(negedge clk);
    check_all_zero("reset_mid_stream");
    reset = 1'b0;
    load_expect();
    pulse_start();
    run_stream(-1, 0, -1, -1, 192);
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(3 * i + 7);
    load_expect();
    pulse_start();
    run_stream(-1, 0, -1, 100, 192);
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b1 || sum !== exp_sum || max_val !== exp_max) begin
        n_err++;
        $display("FAIL finish_hold: got done %0b sum %0d max %0d, expected 1 %0d %0d",
                 done, sum, max_val, exp_sum, exp_max);
      end
    end
    ram[0] = DW'(-5);
    for (int i = 1; i < DEPTH; i++) ram[i] = DW'(-7);
    load_expect();
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || rd_addr !== '0 || sum !== '0 || max_val !== '0) begin
      n_err++;
      $display("FAIL restart_init: got busy %0b done %0b rd_addr %0d sum %0d max %0d, expected 1 0 0 0 0",
               busy, done, rd_addr, sum, max_val);
    end
    run_stream(-1, 0, -1, -1, 192);
    n_cmp++;
    if (max_val !== DW'(-5)) begin
      n_err++;
      $display("FAIL first_seed_max: got %0d, expected -5", max_val);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_stall();
    test_reset_mid();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
